// File: rtl/edge_event_scheduler_if.sv
// Event offer handshake between the scheduler (master) and its consumer (slave).
// The index is stable whenever valid is high and ready is low.
interface edge_event_scheduler_if #(
    parameter int IDXW = 5
);
    logic            evt_valid;
    logic [IDXW-1:0] evt_idx;
    logic            evt_ready;

    modport master (
        output evt_valid,
        output evt_idx,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_idx,
        output evt_ready
    );
endinterface

// File: rtl/edge_event_scheduler.sv
// Falling-edge capture into a pending vector, offered round-robin one event at a time.
// Latency: edge -> pending 1 cycle, -> evt_valid 2 cycles; edges on an already-pending, unaccepted line are dropped and counted.
module edge_event_scheduler #(
    parameter int WIDTH = 32,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in,
    input  logic [WIDTH-1:0]       mask,
    edge_event_scheduler_if.master evt_if,
    output logic [WIDTH-1:0]       pending,
    output logic                   overflow,
    output logic [7:0]             drop_count,
    input  logic                   clr_ovf
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_in_q;
    logic [WIDTH-1:0] r_pending;
    logic [IDXW-1:0]  r_idx;
    logic [IDXW-1:0]  r_ptr;
    logic             r_overflow;
    logic [7:0]       r_drop_count;

    logic [WIDTH-1:0] w_fe;
    logic [WIDTH-1:0] w_acc_vec;
    logic [WIDTH-1:0] w_drop_vec;
    logic [WIDTH-1:0] w_pending_nxt;
    logic             w_accept;
    logic             w_drop;
    logic             w_load_idx;
    logic             w_found;
    logic [IDXW-1:0]  w_sel;
    logic [IDXW-1:0]  w_ptr_nxt;

    assign w_fe       = r_in_q & ~in & mask;
    assign w_accept   = (r_state == OFFER) && evt_if.evt_ready;
    assign w_acc_vec  = w_accept ? ({{(WIDTH-1){1'b0}}, 1'b1} << r_idx) : '0;
    // An edge landing on the cycle its line is accepted re-arms the line instead of dropping.
    assign w_drop_vec = w_fe & r_pending & ~w_acc_vec;
    assign w_drop     = |w_drop_vec;
    assign w_pending_nxt = (r_pending & ~w_acc_vec) | w_fe;
    assign w_ptr_nxt  = (r_idx == IDXW'(WIDTH - 1)) ? '0 : r_idx + 1'b1;

    // Round-robin search: first pending line at or above ptr, wrapping past WIDTH-1.
    always_comb begin
        int              j;
        logic [IDXW-1:0] cand;
        w_found = 1'b0;
        w_sel   = '0;
        j       = 0;
        cand    = '0;
        for (int k = 0; k < WIDTH; k++) begin
            j = int'(r_ptr) + k;
            if (j >= WIDTH) begin
                j = j - WIDTH;
            end
            cand = IDXW'(j);
            if (!w_found && r_pending[cand]) begin
                w_found = 1'b1;
                w_sel   = cand;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_idx  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = OFFER;
                    w_load_idx  = 1'b1;
                end
            end
            OFFER: begin
                if (evt_if.evt_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_q    <= '0;
            r_pending <= '0;
        end else begin
            r_in_q    <= in;
            r_pending <= w_pending_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx <= '0;
            r_ptr <= '0;
        end else begin
            if (w_load_idx) begin
                r_idx <= w_sel;
            end
            if (w_accept) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    // A drop in the same cycle as a clear wins, so the clear never hides a fresh loss.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clr_ovf) begin
                r_drop_count <= 8'd1;
            end else if (r_drop_count != 8'hFF) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end else if (clr_ovf) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end
    end

    assign evt_if.evt_valid = (r_state == OFFER);
    assign evt_if.evt_idx   = r_idx;
    assign pending          = r_pending;
    assign overflow         = r_overflow;
    assign drop_count       = r_drop_count;

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Directed stimulus with a scoreboard of expected event indices popped by a handshake monitor.
module tb_edge_event_scheduler;

    localparam int WIDTH = 32;
    localparam int IDXW  = 5;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] pending;
    logic             overflow;
    logic [7:0]       drop_count;
    logic             clr_ovf;

    int tests;
    int fails;
    int exp_q[$];

    edge_event_scheduler_if #(.IDXW(IDXW)) u_if ();

    edge_event_scheduler #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .in         (in),
        .mask       (mask),
        .evt_if     (u_if),
        .pending    (pending),
        .overflow   (overflow),
        .drop_count (drop_count),
        .clr_ovf    (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n             = 1'b0;
        in                = '1;
        mask              = '1;
        u_if.evt_ready    = 1'b0;
        clr_ovf           = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
    endtask

    // Every accepted handshake must match the oldest expected index.
    always @(negedge clk) begin
        if (rst_n && u_if.evt_valid && u_if.evt_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL accept_unexpected: got idx %0d expected no event", u_if.evt_idx);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(u_if.evt_idx) != e) begin
                    fails++;
                    $display("FAIL accept_idx: got %0d expected %0d", u_if.evt_idx, e);
                end
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        in = '1;
        mask = '1;
        u_if.evt_ready = 1'b0;
        clr_ovf = 1'b0;
        #3;
        chk("rst_valid", 32'(u_if.evt_valid), 32'd0);
        chk("rst_idx", 32'(u_if.evt_idx), 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        step(1);
        rst_n = 1'b1;
        step(3);
        chk("high_at_release_pending", pending, 32'd0);
        chk("high_at_release_valid", 32'(u_if.evt_valid), 32'd0);

        // single event on line 3
        u_if.evt_ready = 1'b1;
        exp_q.push_back(3);
        in[3] = 1'b0;
        step(1);
        chk("single_pending_set", pending, 32'h8);
        chk("single_valid_early", 32'(u_if.evt_valid), 32'd0);
        step(1);
        chk("single_valid", 32'(u_if.evt_valid), 32'd1);
        chk("single_idx", 32'(u_if.evt_idx), 32'd3);
        step(1);
        chk("single_pending_clr", pending, 32'd0);
        chk("single_valid_gap", 32'(u_if.evt_valid), 32'd0);
        in[3] = 1'b1;
        step(3);
        chk("rise_no_event", pending, 32'd0);

        // round-robin from ptr=0
        do_reset();
        u_if.evt_ready = 1'b1;
        exp_q.push_back(0);
        exp_q.push_back(5);
        exp_q.push_back(31);
        in[0] = 1'b0; in[5] = 1'b0; in[31] = 1'b0;
        step(1);
        chk("rr_pending", pending, 32'h8000_0021);
        step(8);
        chk("rr_drained1", 32'(exp_q.size()), 32'd0);
        in = '1;
        step(2);
        exp_q.push_back(0);
        exp_q.push_back(31);
        in[0] = 1'b0; in[31] = 1'b0;
        step(6);
        chk("rr_drained2", 32'(exp_q.size()), 32'd0);
        chk("rr_pending_end", pending, 32'd0);

        // backpressure with a drop, then edge coinciding with accept
        do_reset();
        in[3] = 1'b0;
        step(2);
        chk("bp_valid", 32'(u_if.evt_valid), 32'd1);
        in[3] = 1'b1;
        step(1);
        in[3] = 1'b0;
        step(1);
        chk("bp_overflow", 32'(overflow), 32'd1);
        chk("bp_drop_count", 32'(drop_count), 32'd1);
        in[3] = 1'b1;
        for (int c = 0; c < 7; c++) begin
            step(1);
            chk("bp_idx_held", 32'(u_if.evt_idx), 32'd3);
            chk("bp_valid_held", 32'(u_if.evt_valid), 32'd1);
        end
        exp_q.push_back(3);
        exp_q.push_back(3);
        u_if.evt_ready = 1'b1;
        in[3] = 1'b0;
        step(1);
        chk("acc_edge_pending", pending, 32'h8);
        chk("acc_edge_no_drop", 32'(drop_count), 32'd1);
        step(2);
        chk("acc_edge_pending_clr", pending, 32'd0);
        chk("acc_edge_drained", 32'(exp_q.size()), 32'd0);

        // masking
        do_reset();
        u_if.evt_ready = 1'b1;
        mask[7] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in[7] = 1'b0;
            step(1);
            chk("mask_valid_lo", 32'(u_if.evt_valid), 32'd0);
            in[7] = 1'b1;
            step(1);
            chk("mask_valid_hi", 32'(u_if.evt_valid), 32'd0);
        end
        chk("mask_pending", pending, 32'd0);
        mask = '1;
        u_if.evt_ready = 1'b0;
        in[7] = 1'b0;
        step(1);
        mask[7] = 1'b0;
        step(1);
        chk("mask_keeps_pending", pending, 32'h80);
        exp_q.push_back(7);
        u_if.evt_ready = 1'b1;
        step(1);
        chk("mask_accept_clr", pending, 32'd0);

        // drop counter saturation and clear
        do_reset();
        in[1] = 1'b0;
        step(2);
        for (int d = 1; d <= 300; d++) begin
            in[1] = 1'b1;
            step(1);
            in[1] = 1'b0;
            step(1);
            if (d == 1) chk("sat_first", 32'(drop_count), 32'd1);
            if (d == 255) chk("sat_255", 32'(drop_count), 32'd255);
        end
        chk("sat_300", 32'(drop_count), 32'd255);
        chk("sat_overflow", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        chk("clr_count", 32'(drop_count), 32'd0);
        chk("clr_overflow", 32'(overflow), 32'd0);
        in[1] = 1'b1;
        step(1);
        in[1] = 1'b0;
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        chk("clr_drop_overflow", 32'(overflow), 32'd1);
        chk("clr_drop_count", 32'(drop_count), 32'd1);
        exp_q.push_back(1);
        u_if.evt_ready = 1'b1;
        step(1);
        chk("sat_pending_clr", pending, 32'd0);

        // async reset mid-offer
        do_reset();
        in[9] = 1'b0;
        step(2);
        chk("ar_valid_before", 32'(u_if.evt_valid), 32'd1);
        chk("ar_idx_before", 32'(u_if.evt_idx), 32'd9);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(u_if.evt_valid), 32'd0);
        chk("ar_pending", pending, 32'd0);
        chk("ar_idx", 32'(u_if.evt_idx), 32'd0);
        do_reset();
        chk("ar_after_pending", pending, 32'd0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
